// File: rtl/keypad_fifo.sv
// Keypad scanner consumer: debounces held keydata, pushes each press once into a
// first-word-fall-through FIFO and clears the scanner through the kpdreset/resetkpd handshake.
//
// state | meaning
// IDLE  | waiting for nonzero keydata
// DEB   | candidate code must stay stable for DEBOUNCE samples
// PUSH  | one cycle: write candidate or flag overflow
// CLR   | kpdreset high, waiting for scanner ack
// CLRW  | kpdreset low, waiting for ack to drop
// REL   | waiting for RELEASE consecutive zero samples
module keypad_fifo #(
   parameter int DEPTH    = 8,
   parameter int AW       = 3,
   parameter int DEBOUNCE = 4,
   parameter int RELEASE  = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    keydata,
   input  logic          resetkpd,
   output logic          kpdreset,
   input  logic          rd,
   output logic [7:0]    dout,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   input  logic          ovf_clr,
   output logic          overflow
);

   localparam int TMAX = (DEBOUNCE > RELEASE) ? DEBOUNCE : RELEASE;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] DEB_LOAD = TW'(DEBOUNCE - 1);
   localparam logic [TW-1:0] REL_LOAD = TW'(RELEASE);
   localparam logic [TW-1:0] TC       = TW'(1);
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, DEB, PUSH, CLR, CLRW, REL} state_t;

   state_t          state;
   logic [7:0]      cand;
   logic [TW-1:0]   tmr;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   rd_ptr_nxt;
   logic [AW:0]     count_nxt;
   logic            push;
   logic            pop;

   assign push       = (state == PUSH) && !full;
   assign pop        = rd && !empty;
   assign rd_ptr_nxt = rd_ptr + {{(AW-1){1'b0}}, pop};
   assign count_nxt  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

   // Timers count down to a terminal count of 1, reloaded on entry to DEB and REL.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cand     <= 8'h00;
         tmr      <= '0;
         kpdreset <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (keydata != 8'h00) begin
                  cand <= keydata;
                  if (DEBOUNCE == 1) begin
                     state <= PUSH;
                  end else begin
                     tmr   <= DEB_LOAD;
                     state <= DEB;
                  end
               end
            end
            DEB: begin
               if (keydata != cand) begin
                  state <= IDLE;
                  tmr   <= '0;
               end else if (tmr == TC) begin
                  state <= PUSH;
                  tmr   <= '0;
               end else begin
                  tmr <= tmr - TC;
               end
            end
            PUSH: begin
               state    <= CLR;
               kpdreset <= 1'b1;
            end
            CLR: begin
               if (resetkpd) begin
                  state    <= CLRW;
                  kpdreset <= 1'b0;
               end
            end
            CLRW: begin
               if (!resetkpd) begin
                  state <= REL;
                  tmr   <= REL_LOAD;
               end
            end
            REL: begin
               // Scanner re-latched a still-held key: clear it again without pushing.
               if (keydata != 8'h00) begin
                  state    <= CLR;
                  kpdreset <= 1'b1;
                  tmr      <= '0;
               end else if (tmr == TC) begin
                  state <= IDLE;
                  tmr   <= '0;
               end else begin
                  tmr <= tmr - TC;
               end
            end
            default: begin
               state    <= IDLE;
               kpdreset <= 1'b0;
               tmr      <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cand;
   end

   // dout is registered as the next head, bypassing the array when the new entry becomes the head.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         dout     <= 8'h00;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         empty  <= (count_nxt == '0);
         full   <= (count_nxt == DEPTH_C);
         dout   <= (push && (wr_ptr == rd_ptr_nxt)) ? cand : mem[rd_ptr_nxt];
         if ((state == PUSH) && full) overflow <= 1'b1;
         else if (ovf_clr)            overflow <= 1'b0;
      end
   end

endmodule
